// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types for the round-robin grant scheduler.
// Requester count, index width, FSM encoding and decode helper.
package rr_grant_scheduler_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic req_t idx_decode(input idx_t idx);
    req_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_pick.sv
// Rotating priority picker: first set request at or after ptr.
// Purely combinational; wraps from index 15 back to 0.
module rr_priority_pick
  import rr_grant_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  idx_t cand;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + idx_t'(k);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner scheduler for a 16-way select resource.
// Hold timer forces revoke; one gap cycle separates grants.
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic [N_REQ-1:0] grant_onehot_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 ||
      (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
    $error("rr_grant_scheduler: bad MAX_HOLD/CNT_W");
  end

  state_e           state_q, state_d;
  idx_t             ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  idx_t             idx_q, idx_d;
  req_t             onehot_q, onehot_d;
  logic             tmo_q, tmo_d;
  logic             busy_q, busy_d;

  logic             pick_any;
  idx_t             pick_idx;
  logic             withdraw;
  logic             expire;
  logic             revoke;

  rr_priority_pick u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign withdraw = ~req_i[idx_q];
  assign expire   = (hold_q == HOLD_MAX);
  assign revoke   = release_i | withdraw | expire;

  // Next state, grant bookkeeping and registered output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          valid_d = 1'b1;
          idx_d   = pick_idx;
          hold_d  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (revoke) begin
          state_d = ST_GAP;
          valid_d = 1'b0;
          ptr_d   = idx_q + idx_t'(1);
          hold_d  = '0;
          tmo_d   = ~release_i & ~withdraw & expire;
        end else begin
          hold_d  = hold_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
    onehot_d = valid_d ? idx_decode(idx_d) : '0;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
    end
  end

  assign grant_valid_o  = valid_q;
  assign grant_idx_o    = idx_q;
  assign grant_onehot_o = onehot_q;
  assign timeout_o      = tmo_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler.
// Expected grant owners are queued when requests are driven.
module tb_rr_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        rel;
  logic        gv;
  logic [3:0]  gidx;
  logic [15:0] goh;
  logic        tmo;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  rr_grant_scheduler #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .release_i      (rel),
    .grant_valid_o  (gv),
    .grant_idx_o    (gidx),
    .grant_onehot_o (goh),
    .timeout_o      (tmo),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rel = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rel = 1'b0;
    req = 16'hFFFF;
    tick();
    tick();
    n_cmp++;
    if (gv !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", gv);
    end
    n_cmp++;
    if (gidx !== 4'd0) begin
      n_bad++; $display("FAIL rst_idx: got %0d want 0", gidx);
    end
    n_cmp++;
    if (goh !== 16'h0) begin
      n_bad++; $display("FAIL rst_onehot: got %h want 0", goh);
    end
    n_cmp++;
    if (tmo !== 1'b0) begin
      n_bad++; $display("FAIL rst_timeout: got %b want 0", tmo);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 10; c++) begin
      rel = (c == 3);
      tick();
      n_cmp++;
      if (gv !== 1'b0 || busy !== 1'b0 || goh !== 16'h0) begin
        n_bad++;
        $display("FAIL idle_c%0d: got v=%b b=%b oh=%h want 0/0/0",
                 c, gv, busy, goh);
      end
    end
    rel = 1'b0;
  endtask

  task automatic test_single();
    int e;
    do_reset();
    req = 16'h0001;
    exp_q.push_back(0);
    exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (gv !== 1'b1 || gidx !== 4'(e) || goh !== 16'h0001) begin
      n_bad++;
      $display("FAIL single_c1: got v=%b i=%0d oh=%h want 1/%0d/0001",
               gv, gidx, goh, e);
    end
    tick();
    tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    n_cmp++;
    if (gv !== 1'b0 || goh !== 16'h0 || tmo !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_gap: got v=%b oh=%h t=%b b=%b want 0/0/0/1",
               gv, goh, tmo, busy);
    end
    tick();
    n_cmp++;
    if (gv !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: got v=%b b=%b want 0/0", gv, busy);
    end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (gv !== 1'b1 || gidx !== 4'(e) || goh !== 16'h0001) begin
      n_bad++;
      $display("FAIL single_c6: got v=%b i=%0d oh=%h want 1/%0d/0001",
               gv, gidx, goh, e);
    end
  endtask

  task automatic test_rr_all();
    int e;
    int k;
    do_reset();
    req = 16'hFFFF;
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    for (int g = 0; g < 17; g++) begin
      k = 0;
      while (gv !== 1'b1 && k < 8) begin
        tick();
        k++;
      end
      n_cmp++;
      if (gv !== 1'b1 || exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rr_wait_%0d: got v=%b q=%0d want grant",
                 g, gv, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (gidx !== 4'(e) || goh !== (16'h1 << e)) begin
          n_bad++;
          $display("FAIL rr_grant_%0d: got i=%0d oh=%h want %0d",
                   g, gidx, goh, e);
        end
      end
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
    end
  endtask

  task automatic test_wrap();
    int e;
    int k;
    do_reset();
    req = 16'h8001;
    exp_q.push_back(0);
    exp_q.push_back(15);
    exp_q.push_back(0);
    for (int g = 0; g < 3; g++) begin
      k = 0;
      while (gv !== 1'b1 && k < 8) begin
        tick();
        k++;
      end
      n_cmp++;
      if (gv !== 1'b1 || exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wrap_wait_%0d: got v=%b want grant", g, gv);
      end else begin
        e = exp_q.pop_front();
        if (gidx !== 4'(e) || goh !== (16'h1 << e)) begin
          n_bad++;
          $display("FAIL wrap_grant_%0d: got i=%0d oh=%h want %0d",
                   g, gidx, goh, e);
        end
      end
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
    end
    req = 16'h8000;
    exp_q.push_back(15);
    k = 0;
    while (gv !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (gv !== 1'b1 || gidx !== 4'(e)) begin
      n_bad++;
      $display("FAIL withdraw_grant: got v=%b i=%0d want 1/%0d", gv, gidx, e);
    end
    req = 16'h0000;
    tick();
    n_cmp++;
    if (gv !== 1'b0 || tmo !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL withdraw_drop: got v=%b t=%b b=%b want 0/0/1",
               gv, tmo, busy);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 16'h0010;
    tick();
    for (int c = 1; c <= 8; c++) begin
      n_cmp++;
      if (gv !== 1'b1 || gidx !== 4'd4 || tmo !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_c%0d: got v=%b i=%0d t=%b want 1/4/0",
                 c, gv, gidx, tmo);
      end
      tick();
    end
    n_cmp++;
    if (tmo !== 1'b1 || gv !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_pulse: got t=%b v=%b b=%b want 1/0/1", tmo, gv, busy);
    end
    tick();
    n_cmp++;
    if (tmo !== 1'b0 || gv !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_after: got t=%b v=%b b=%b want 0/0/0", tmo, gv, busy);
    end
    tick();
    n_cmp++;
    if (gv !== 1'b1 || gidx !== 4'd4 || goh !== 16'h0010) begin
      n_bad++;
      $display("FAIL tmo_regrant: got v=%b i=%0d oh=%h want 1/4/0010",
               gv, gidx, goh);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    req = 16'h0010;
    tick();
    for (int c = 0; c < 7; c++) tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    n_cmp++;
    if (tmo !== 1'b0 || gv !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL coincide: got t=%b v=%b b=%b want 0/0/1", tmo, gv, busy);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    int k;
    do_reset();
    req = 16'h0081;
    exp_q.push_back(0);
    exp_q.push_back(7);
    for (int g = 0; g < 2; g++) begin
      k = 0;
      while (gv !== 1'b1 && k < 8) begin
        tick();
        k++;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (gv !== 1'b1 || gidx !== 4'(e)) begin
        n_bad++;
        $display("FAIL mid_grant_%0d: got v=%b i=%0d want 1/%0d",
                 g, gv, gidx, e);
      end
      if (g == 0) begin
        tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
      end
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (gv !== 1'b0 || gidx !== 4'd0 || goh !== 16'h0 ||
        tmo !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst: got v=%b i=%0d oh=%h t=%b b=%b want zeros",
               gv, gidx, goh, tmo, busy);
    end
    exp_q.push_back(0);
    k = 0;
    while (gv !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (gv !== 1'b1 || gidx !== 4'(e) || goh !== (16'h1 << e)) begin
      n_bad++;
      $display("FAIL mid_ptr: got v=%b i=%0d oh=%h want 1/%0d",
               gv, gidx, goh, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    rel = 1'b0;
    req = '0;
    test_reset();
    test_single();
    test_rr_all();
    test_wrap();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1);
  end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one 16-way one-hot select resource among 16 requesters.
- Each cycle it sequences which requester owns the resource. It presents a 4-bit grant index and its decoded 16-bit one-hot grant.
- A hold timer enforces fairness, and a mandatory gap cycle prevents two grants from overlapping.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may stay active before forced revoke (1..255)
- CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req  in  16  request vector; bit i = requester i wants the resource
- release  in  1  owner finished; one-cycle pulse, ignored unless state GRANT
- grant_valid  out  1  a grant is active
- grant_idx  out  4  index of current owner (valid only when grant_valid)
- grant_onehot  out  16  one-hot of grant_idx when grant_valid, else all zero
- timeout  out  1  one-cycle pulse: current grant was force-revoked by the hold timer
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at clk edge) applies regardless of state:
  - state=IDLE, ptr=0, hold_cnt=0
  - grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0, busy=0
- All outputs are registered, with no combinational path from req to outputs.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - Next cycle: state=GRANT, grant_idx=selected, grant_valid=1, hold_cnt=1.
  - Latency is 1 cycle from req visible to grant_valid.
  - If req==0, remain in IDLE.
- GRANT, each cycle, with revoke conditions checked in priority order:
  - (a) release=1: orderly end.
  - (b) req[grant_idx]==0: requester withdrew.
  - (c) hold_cnt==MAX_HOLD: force revoke; timeout=1 for exactly one cycle, coincident with the transition into GAP.
  - On any revoke: next state GAP, grant_valid=0, grant_onehot=0, ptr=grant_idx+1 (4-bit wrap, 15 -> 0).
  - Otherwise hold_cnt increments.
  - If release and timeout conditions coincide, release wins and timeout stays 0.
- GAP:
  - Exactly one cycle with no grant (break-before-make).
  - Next state is IDLE, where arbitration happens the following cycle.
  - Minimum spacing between consecutive grants is therefore 2 idle cycles.
- Fairness:
  - The last owner has lowest priority in the next arbitration.
  - With all 16 requesting, grants cycle 0, 1, ..., 15, 0.
  - A sole requester is re-granted after each gap.
- Pulse rules:
  - release in IDLE or GAP is ignored.
  - req changes during GAP affect only the next IDLE arbitration.
- grant_onehot[i] = grant_valid & (grant_idx==i), registered together with grant_idx.
- Reset mid-GRANT drops the grant on the same edge; ptr returns to 0.

Decomposition:
- Shared package holds:
  - N_REQ=16 and IDX_W=4
  - State encoding: IDLE=2'd0, GRANT=2'd1, GAP=2'd2
  - The req-vector type width
- Sub-module rr_priority_pick: purely combinational. Inputs req[15:0] and ptr[3:0]; outputs any (1) and idx (4), giving the first set bit at or after ptr with wrap.
- The top level holds the FSM, hold counter, ptr and output registers.
- The one-hot output is a 4-to-16 decode of grant_idx gated by grant_valid.

Test Plan:
- Reset, then req=16'h0000 for 10 cycles -> grant_valid=0, busy=0, grant_onehot=0 throughout.
- req=16'h0001 from cycle 0, release pulse at cycle 3 -> grant_idx=0 / onehot=16'h0001 at cycle 1; grant drops at cycle 4; GAP; re-grant of 0 at cycle 6.
- req=16'hFFFF held, release pulse each second grant cycle -> grant_idx sequence 0, 1, 2, ..., 15, 0; wraps without skipping.
- req=16'h8001, ptr at 1 (after a grant to 0) -> next grant_idx=15, then 0; verifies wrap-around priority.
- req=16'h0010 held, no release, MAX_HOLD=8 -> grant active 8 cycles, timeout=1 for one cycle, grant_valid=0, one GAP cycle, then re-grant of 4.
- Edge cases:
  - rst=1 during GRANT of idx 7 -> next cycle all outputs zero, state IDLE.
  - Same-cycle release and hold expiry -> timeout stays 0.
